// File: rtl/mpf_vtp_svc_arb.sv
// mpf_vtp_svc_arb: shares one VTP translation service among N_PORTS shim ports.
// Each port gets a round-robin grant. Its request is retagged with the lowest
// free service tag and held in a single output register. A response is sent
// back to the port that issued it, with the port-local tag put back.
//
// Packed layouts (MSB first):
//   request : {pageVA[VA_W-1:0], isSpeculative, tag[TW-1:0]}
//   response: {pagePA[PA_W-1:0], error, isBigPage, mayCache, tag[TW-1:0]}
// port_req holds port p at bits [p*REQ_W +: REQ_W].
//
// Optional feature macro: MPF_VTP_SVC_ARB_STATS_EN. When it is defined,
// tag_exhausted_cycles is a saturating count of cycles in which a request was
// waiting and no tag was free. When it is undefined, the output is tied to 0.
//
// Handshakes: a beat moves on a rising edge where valid && ready. A source
// holds its payload stable while valid is high and ready is low. Responses
// have no backpressure.
`ifndef MPF_VTP_MAX_SVC_REQS
`define MPF_VTP_MAX_SVC_REQS 32
`endif

module mpf_vtp_svc_arb #(
    parameter int N_PORTS = 2,
    parameter int N_TAGS  = `MPF_VTP_MAX_SVC_REQS,
    parameter int VA_W    = 36,
    parameter int PA_W    = 28,
    localparam int TW     = $clog2(N_TAGS),
    localparam int PW     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1,
    localparam int REQ_W  = VA_W + 1 + TW,
    localparam int RSP_W  = PA_W + 3 + TW
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_PORTS-1:0]       port_req_valid,
    input  logic [N_PORTS*REQ_W-1:0] port_req,
    output logic [N_PORTS-1:0]       port_req_ready,
    output logic [N_PORTS-1:0]       port_rsp_valid,
    output logic [RSP_W-1:0]         port_rsp,
    output logic                     svc_req_valid,
    output logic [REQ_W-1:0]         svc_req,
    input  logic                     svc_req_ready,
    input  logic                     svc_rsp_valid,
    input  logic [RSP_W-1:0]         svc_rsp,
    output logic [31:0]              tag_exhausted_cycles
);

    logic [N_TAGS-1:0]  free_q, free_d;
    logic [PW-1:0]      tag_port_q [N_TAGS];
    logic [PW-1:0]      tag_port_d [N_TAGS];
    logic [TW-1:0]      tag_local_q [N_TAGS];
    logic [TW-1:0]      tag_local_d [N_TAGS];
    logic [PW-1:0]      rr_q, rr_d;
    logic               svc_req_valid_q, svc_req_valid_d;
    logic [REQ_W-1:0]   svc_req_q, svc_req_d;
    logic [N_PORTS-1:0] port_rsp_valid_q, port_rsp_valid_d;
    logic [RSP_W-1:0]   port_rsp_q, port_rsp_d;

    logic               any_free;
    logic [TW-1:0]      alloc_tag;
    logic               out_open;
    logic               grant_found;
    logic [PW-1:0]      grant_idx;
    logic [PW-1:0]      cand;
    logic [N_PORTS-1:0] grant;
    logic [REQ_W-1:0]   req_sel;
    logic [TW-1:0]      rsp_tag;
    logic               rsp_ok;

    // Pick the lowest-numbered free tag. This reads the registered bitmap, so a
    // tag freed on this edge cannot be handed out until the next cycle.
    always_comb begin
        any_free  = |free_q;
        alloc_tag = '0;
        for (int i = N_TAGS - 1; i >= 0; i--) begin
            if (free_q[i]) alloc_tag = TW'(i);
        end
    end

    // Round-robin grant. It needs a free tag and an output register that is
    // empty or draining this cycle.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        grant       = '0;
        req_sel     = '0;
        out_open    = !svc_req_valid_q || svc_req_ready;
        if (!reset && any_free && out_open) begin
            for (int i = 0; i < N_PORTS; i++) begin
                cand = PW'((int'(rr_q) + i) % N_PORTS);
                if (!grant_found && port_req_valid[cand]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand;
                end
            end
            if (grant_found) grant[grant_idx] = 1'b1;
        end
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant_idx == PW'(i)) req_sel = port_req[i*REQ_W +: REQ_W];
        end
    end

    assign rsp_tag = svc_rsp[TW-1:0];
    assign rsp_ok  = svc_rsp_valid && !free_q[rsp_tag];

    // Next state: allocate and load the output register, route responses and free their tags.
    always_comb begin
        free_d           = free_q;
        tag_port_d       = tag_port_q;
        tag_local_d      = tag_local_q;
        rr_d             = rr_q;
        svc_req_valid_d  = svc_req_valid_q;
        svc_req_d        = svc_req_q;
        port_rsp_valid_d = '0;
        port_rsp_d       = port_rsp_q;
        if (svc_req_valid_q && svc_req_ready) svc_req_valid_d = 1'b0;
        if (grant_found) begin
            free_d[alloc_tag]      = 1'b0;
            tag_port_d[alloc_tag]  = grant_idx;
            tag_local_d[alloc_tag] = req_sel[TW-1:0];
            svc_req_valid_d        = 1'b1;
            svc_req_d              = {req_sel[REQ_W-1:TW], alloc_tag};
            rr_d = (int'(grant_idx) == N_PORTS - 1) ? '0 : grant_idx + 1'b1;
        end
        // The allocated tag was free and the response tag was in use, so they never collide.
        if (rsp_ok) begin
            free_d[rsp_tag]                       = 1'b1;
            port_rsp_valid_d[tag_port_q[rsp_tag]] = 1'b1;
            port_rsp_d = {svc_rsp[RSP_W-1:TW], tag_local_q[rsp_tag]};
        end
    end

    // State registers. Reset frees every tag and drops work in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            free_q           <= '1;
            rr_q             <= '0;
            svc_req_valid_q  <= 1'b0;
            svc_req_q        <= '0;
            port_rsp_valid_q <= '0;
            port_rsp_q       <= '0;
            for (int i = 0; i < N_TAGS; i++) begin
                tag_port_q[i]  <= '0;
                tag_local_q[i] <= '0;
            end
        end else begin
            free_q           <= free_d;
            rr_q             <= rr_d;
            svc_req_valid_q  <= svc_req_valid_d;
            svc_req_q        <= svc_req_d;
            port_rsp_valid_q <= port_rsp_valid_d;
            port_rsp_q       <= port_rsp_d;
            tag_port_q       <= tag_port_d;
            tag_local_q      <= tag_local_d;
        end
    end

    assign port_req_ready = grant;
    assign svc_req_valid  = svc_req_valid_q;
    assign svc_req        = svc_req_q;
    assign port_rsp_valid = port_rsp_valid_q;
    assign port_rsp       = port_rsp_q;

`ifdef MPF_VTP_SVC_ARB_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Count cycles in which a request is waiting and every tag is busy. The count saturates.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((|port_req_valid) && !any_free && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    // Stall counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign tag_exhausted_cycles = stall_cnt_q;
`else
    assign tag_exhausted_cycles = '0;
`endif

`ifndef SYNTHESIS
    // A response for a tag that is already free is stale, for example from
    // before a reset. It is dropped, and this flags it.
    always_ff @(posedge clk) begin
        if (!reset && svc_rsp_valid)
            assert (!free_q[rsp_tag])
            else $error("mpf_vtp_svc_arb: response for free tag %0d dropped", rsp_tag);
    end
`endif

endmodule

// File: tb/tb_mpf_vtp_svc_arb.sv
// Directed bench for mpf_vtp_svc_arb. Inputs change 1 ns after a rising edge.
// Outputs are sampled on the falling edge.
module tb_mpf_vtp_svc_arb;

    localparam int N_PORTS = 2;
    localparam int N_TAGS  = 32;
    localparam int VA_W    = 36;
    localparam int PA_W    = 28;
    localparam int TW      = 5;
    localparam int REQ_W   = VA_W + 1 + TW;
    localparam int RSP_W   = PA_W + 3 + TW;
`ifdef MPF_VTP_SVC_ARB_STATS_EN
    localparam logic [31:0] EXP_STALL = 32'd10;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
`endif

    logic                     clk = 1'b0;
    logic                     reset;
    logic [N_PORTS-1:0]       port_req_valid;
    logic [N_PORTS*REQ_W-1:0] port_req;
    logic [N_PORTS-1:0]       port_req_ready;
    logic [N_PORTS-1:0]       port_rsp_valid;
    logic [RSP_W-1:0]         port_rsp;
    logic                     svc_req_valid;
    logic [REQ_W-1:0]         svc_req;
    logic                     svc_req_ready;
    logic                     svc_rsp_valid;
    logic [RSP_W-1:0]         svc_rsp;
    logic [31:0]              tag_exhausted_cycles;

    int errors = 0;
    int checks = 0;

    mpf_vtp_svc_arb #(.N_PORTS(N_PORTS), .N_TAGS(N_TAGS), .VA_W(VA_W), .PA_W(PA_W)) dut (
        .clk(clk), .reset(reset),
        .port_req_valid(port_req_valid), .port_req(port_req), .port_req_ready(port_req_ready),
        .port_rsp_valid(port_rsp_valid), .port_rsp(port_rsp),
        .svc_req_valid(svc_req_valid), .svc_req(svc_req), .svc_req_ready(svc_req_ready),
        .svc_rsp_valid(svc_rsp_valid), .svc_rsp(svc_rsp),
        .tag_exhausted_cycles(tag_exhausted_cycles)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1);
    end

    function automatic logic [REQ_W-1:0] mk_req(input logic [VA_W-1:0] va, input logic spec,
                                                 input logic [TW-1:0] tag);
        return {va, spec, tag};
    endfunction

    function automatic logic [RSP_W-1:0] mk_rsp(input logic [PA_W-1:0] pa, input logic err,
                                                 input logic big, input logic mc,
                                                 input logic [TW-1:0] tag);
        return {pa, err, big, mc, tag};
    endfunction

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset          = 1'b1;
        port_req_valid = '0;
        port_req       = '0;
        svc_req_ready  = 1'b0;
        svc_rsp_valid  = 1'b0;
        svc_rsp        = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset          = 1'b1;
        svc_req_ready  = 1'b1;
        svc_rsp_valid  = 1'b0;
        svc_rsp        = '0;
        port_req       = {mk_req(36'h2, 1'b0, 5'd2), mk_req(36'h1, 1'b0, 5'd1)};
        port_req_valid = 2'b11;
        cyc;
        cyc;
        @(negedge clk);
        checks++; if (port_req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected %b", port_req_ready, 2'b00); end
        checks++; if (svc_req_valid !== 1'b0) begin errors++; $display("FAIL reset_svc_valid: got %b expected 0", svc_req_valid); end
        checks++; if (port_rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 00", port_rsp_valid); end
        checks++; if (tag_exhausted_cycles !== 32'd0) begin errors++; $display("FAIL reset_stats: got %0d expected 0", tag_exhausted_cycles); end
        reset = 1'b0;
        #1;
        checks++; if (port_req_ready !== 2'b01) begin errors++; $display("FAIL reset_rr_start: got %b expected %b", port_req_ready, 2'b01); end
        port_req_valid = '0;
    endtask

    task automatic test_single;
        do_reset;
        svc_req_ready      = 1'b1;
        port_req[REQ_W-1:0] = mk_req(36'h123, 1'b0, 5'd7);
        port_req_valid     = 2'b01;
        @(negedge clk);
        checks++; if (port_req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b expected 01", port_req_ready); end
        cyc;
        port_req_valid = '0;
        @(negedge clk);
        checks++; if (svc_req_valid !== 1'b1) begin errors++; $display("FAIL single_svc_valid: got %b expected 1", svc_req_valid); end
        checks++; if (svc_req !== mk_req(36'h123, 1'b0, 5'd0)) begin errors++; $display("FAIL single_svc_req: got %h expected %h", svc_req, mk_req(36'h123, 1'b0, 5'd0)); end
        cyc;
        svc_rsp_valid = 1'b1;
        svc_rsp       = mk_rsp(28'h456, 1'b0, 1'b0, 1'b0, 5'd0);
        @(negedge clk);
        checks++; if (svc_req_valid !== 1'b0) begin errors++; $display("FAIL single_drained: got %b expected 0", svc_req_valid); end
        checks++; if (port_rsp_valid !== 2'b00) begin errors++; $display("FAIL single_rsp_early: got %b expected 00", port_rsp_valid); end
        cyc;
        svc_rsp_valid = 1'b0;
        @(negedge clk);
        checks++; if (port_rsp_valid !== 2'b01) begin errors++; $display("FAIL single_rsp_valid: got %b expected 01", port_rsp_valid); end
        checks++; if (port_rsp !== mk_rsp(28'h456, 1'b0, 1'b0, 1'b0, 5'd7)) begin errors++; $display("FAIL single_rsp: got %h expected %h", port_rsp, mk_rsp(28'h456, 1'b0, 1'b0, 1'b0, 5'd7)); end
        cyc;
        @(negedge clk);
        checks++; if (port_rsp_valid !== 2'b00) begin errors++; $display("FAIL single_rsp_pulse: got %b expected 00", port_rsp_valid); end
    endtask

    task automatic test_alternate;
        logic [REQ_W-1:0] exp_req;
        logic [1:0]       exp_rdy;
        do_reset;
        svc_req_ready  = 1'b1;
        port_req       = {mk_req(36'hB0, 1'b1, 5'd2), mk_req(36'hA0, 1'b0, 5'd1)};
        port_req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
            checks++; if (port_req_ready !== exp_rdy) begin errors++; $display("FAIL alt_ready[%0d]: got %b expected %b", k, port_req_ready, exp_rdy); end
            if (k > 0) begin
                exp_req = ((k - 1) % 2 == 0) ? mk_req(36'hA0, 1'b0, TW'(k - 1)) : mk_req(36'hB0, 1'b1, TW'(k - 1));
                checks++; if (svc_req !== exp_req) begin errors++; $display("FAIL alt_svc_req[%0d]: got %h expected %h", k, svc_req, exp_req); end
            end
            cyc;
        end
        port_req_valid = '0;
        @(negedge clk);
        checks++; if (svc_req !== mk_req(36'hB0, 1'b1, 5'd3)) begin errors++; $display("FAIL alt_last: got %h expected %h", svc_req, mk_req(36'hB0, 1'b1, 5'd3)); end
    endtask

    task automatic test_backpressure;
        do_reset;
        svc_req_ready  = 1'b0;
        port_req       = {mk_req(36'h222, 1'b0, 5'd4), mk_req(36'h111, 1'b0, 5'd3)};
        port_req_valid = 2'b11;
        @(negedge clk);
        checks++; if (port_req_ready !== 2'b01) begin errors++; $display("FAIL bp_first: got %b expected 01", port_req_ready); end
        cyc;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (port_req_ready !== 2'b00) begin errors++; $display("FAIL bp_stall_ready[%0d]: got %b expected 00", i, port_req_ready); end
            checks++; if ({svc_req_valid, svc_req} !== {1'b1, mk_req(36'h111, 1'b0, 5'd0)}) begin errors++; $display("FAIL bp_hold[%0d]: got %b/%h expected 1/%h", i, svc_req_valid, svc_req, mk_req(36'h111, 1'b0, 5'd0)); end
            cyc;
        end
        svc_req_ready = 1'b1;
        @(negedge clk);
        checks++; if (port_req_ready !== 2'b10) begin errors++; $display("FAIL bp_drain_grant: got %b expected 10", port_req_ready); end
        cyc;
        port_req_valid = '0;
        @(negedge clk);
        checks++; if ({svc_req_valid, svc_req} !== {1'b1, mk_req(36'h222, 1'b0, 5'd1)}) begin errors++; $display("FAIL bp_next: got %b/%h expected 1/%h", svc_req_valid, svc_req, mk_req(36'h222, 1'b0, 5'd1)); end
    endtask

    task automatic test_out_of_order;
        logic [TW-1:0]    rtag [3];
        logic [PA_W-1:0]  rpa  [3];
        logic [2:0]       rflg [3];
        logic [1:0]       eport [3];
        logic [TW-1:0]    eloc [3];
        rtag = '{5'd2, 5'd0, 5'd1};
        rpa  = '{28'h222, 28'h200, 28'h211};
        rflg = '{3'b100, 3'b010, 3'b001};
        eport = '{2'b01, 2'b01, 2'b10};
        eloc = '{5'd12, 5'd10, 5'd11};
        do_reset;
        svc_req_ready = 1'b1;
        port_req[REQ_W-1:0] = mk_req(36'h10, 1'b0, 5'd10);
        port_req_valid = 2'b01;
        cyc;
        port_req[2*REQ_W-1:REQ_W] = mk_req(36'h11, 1'b0, 5'd11);
        port_req_valid = 2'b10;
        cyc;
        port_req[REQ_W-1:0] = mk_req(36'h12, 1'b1, 5'd12);
        port_req_valid = 2'b01;
        cyc;
        port_req_valid = '0;
        @(negedge clk);
        checks++; if (svc_req !== mk_req(36'h12, 1'b1, 5'd2)) begin errors++; $display("FAIL ooo_third_req: got %h expected %h", svc_req, mk_req(36'h12, 1'b1, 5'd2)); end
        for (int i = 0; i < 3; i++) begin
            svc_rsp_valid = 1'b1;
            svc_rsp = mk_rsp(rpa[i], rflg[i][2], rflg[i][1], rflg[i][0], rtag[i]);
            cyc;
            svc_rsp_valid = 1'b0;
            @(negedge clk);
            checks++; if (port_rsp_valid !== eport[i]) begin errors++; $display("FAIL ooo_port[%0d]: got %b expected %b", i, port_rsp_valid, eport[i]); end
            checks++; if (port_rsp !== mk_rsp(rpa[i], rflg[i][2], rflg[i][1], rflg[i][0], eloc[i])) begin errors++; $display("FAIL ooo_rsp[%0d]: got %h expected %h", i, port_rsp, mk_rsp(rpa[i], rflg[i][2], rflg[i][1], rflg[i][0], eloc[i])); end
        end
    endtask

    task automatic test_simultaneous;
        do_reset;
        svc_req_ready = 1'b1;
        port_req[REQ_W-1:0] = mk_req(36'h30, 1'b0, 5'd6);
        port_req_valid = 2'b01;
        cyc;
        port_req[2*REQ_W-1:REQ_W] = mk_req(36'h31, 1'b0, 5'd8);
        port_req_valid = 2'b10;
        svc_rsp_valid  = 1'b1;
        svc_rsp        = mk_rsp(28'h300, 1'b0, 1'b0, 1'b0, 5'd0);
        @(negedge clk);
        checks++; if (port_req_ready !== 2'b10) begin errors++; $display("FAIL sim_ready: got %b expected 10", port_req_ready); end
        cyc;
        port_req_valid = '0;
        svc_rsp_valid  = 1'b0;
        @(negedge clk);
        checks++; if (svc_req !== mk_req(36'h31, 1'b0, 5'd1)) begin errors++; $display("FAIL sim_alloc: got %h expected %h", svc_req, mk_req(36'h31, 1'b0, 5'd1)); end
        checks++; if ({port_rsp_valid, port_rsp} !== {2'b01, mk_rsp(28'h300, 1'b0, 1'b0, 1'b0, 5'd6)}) begin errors++; $display("FAIL sim_rsp: got %b/%h expected 01/%h", port_rsp_valid, port_rsp, mk_rsp(28'h300, 1'b0, 1'b0, 1'b0, 5'd6)); end
        port_req[REQ_W-1:0] = mk_req(36'h32, 1'b0, 5'd9);
        port_req_valid = 2'b01;
        cyc;
        port_req_valid = '0;
        @(negedge clk);
        checks++; if (svc_req !== mk_req(36'h32, 1'b0, 5'd0)) begin errors++; $display("FAIL sim_reuse: got %h expected %h", svc_req, mk_req(36'h32, 1'b0, 5'd0)); end
    endtask

    task automatic test_exhaust_and_reset;
        do_reset;
        svc_req_ready = 1'b1;
        port_req[REQ_W-1:0] = mk_req(36'h40, 1'b0, 5'd9);
        port_req_valid = 2'b01;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            checks++; if (port_req_ready !== 2'b01) begin errors++; $display("FAIL exh_ready[%0d]: got %b expected 01", i, port_req_ready); end
            cyc;
        end
        @(negedge clk);
        checks++; if (svc_req !== mk_req(36'h40, 1'b0, 5'd31)) begin errors++; $display("FAIL exh_tag31: got %h expected %h", svc_req, mk_req(36'h40, 1'b0, 5'd31)); end
        checks++; if (port_req_ready !== 2'b00) begin errors++; $display("FAIL exh_full: got %b expected 00", port_req_ready); end
        for (int j = 0; j < 10; j++) begin
            cyc;
            @(negedge clk);
            checks++; if (port_req_ready !== 2'b00) begin errors++; $display("FAIL exh_stall[%0d]: got %b expected 00", j, port_req_ready); end
        end
        checks++; if (tag_exhausted_cycles !== EXP_STALL) begin errors++; $display("FAIL exh_stats: got %0d expected %0d", tag_exhausted_cycles, EXP_STALL); end
        svc_rsp_valid = 1'b1;
        svc_rsp       = mk_rsp(28'h555, 1'b0, 1'b0, 1'b0, 5'd5);
        #1;
        checks++; if (port_req_ready !== 2'b00) begin errors++; $display("FAIL exh_no_same_cycle: got %b expected 00", port_req_ready); end
        cyc;
        svc_rsp_valid = 1'b0;
        @(negedge clk);
        checks++; if ({port_rsp_valid, port_rsp} !== {2'b01, mk_rsp(28'h555, 1'b0, 1'b0, 1'b0, 5'd9)}) begin errors++; $display("FAIL exh_rsp: got %b/%h expected 01/%h", port_rsp_valid, port_rsp, mk_rsp(28'h555, 1'b0, 1'b0, 1'b0, 5'd9)); end
        checks++; if (port_req_ready !== 2'b01) begin errors++; $display("FAIL exh_regrant: got %b expected 01", port_req_ready); end
        cyc;
        @(negedge clk);
        checks++; if (svc_req !== mk_req(36'h40, 1'b0, 5'd5)) begin errors++; $display("FAIL exh_tag5: got %h expected %h", svc_req, mk_req(36'h40, 1'b0, 5'd5)); end
        reset = 1'b1;
        #1;
        checks++; if (port_req_ready !== 2'b00) begin errors++; $display("FAIL mid_reset_ready: got %b expected 00", port_req_ready); end
        checks++; if ({svc_req_valid, port_rsp_valid} !== 3'b000) begin errors++; $display("FAIL mid_reset_valids: got %b expected 000", {svc_req_valid, port_rsp_valid}); end
        checks++; if (tag_exhausted_cycles !== 32'd0) begin errors++; $display("FAIL mid_reset_stats: got %0d expected 0", tag_exhausted_cycles); end
        cyc;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (port_req_ready !== 2'b01) begin errors++; $display("FAIL post_reset_ready: got %b expected 01", port_req_ready); end
        cyc;
        port_req_valid = '0;
        @(negedge clk);
        checks++; if (svc_req !== mk_req(36'h40, 1'b0, 5'd0)) begin errors++; $display("FAIL post_reset_tag0: got %h expected %h", svc_req, mk_req(36'h40, 1'b0, 5'd0)); end
    endtask

    // Test sequence and final report
    initial begin
        do_reset;
        test_reset;
        test_single;
        test_alternate;
        test_backpressure;
        test_out_of_order;
        test_simultaneous;
        test_exhaust_and_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mpf_vtp_svc_arb.md
MPF_VTP_SVC_ARB -- requirements
Module: mpf_vtp_svc_arb

Interface
REQ-001 SHALL have parameter N_PORTS, default 2, range 1..8: number of VTP shim ports sharing one translation service.
REQ-002 SHALL have parameter N_TAGS, default MPF_VTP_MAX_SVC_REQS (32): number of service tags; service tag width TW = log2(N_TAGS).
REQ-003 SHALL have port clk  in  1: single clock, all logic rising-edge.
REQ-004 SHALL have port reset  in  1: asynchronous, active-high.
REQ-005 SHALL have port port_req_valid  in  N_PORTS: per-port lookup request valid.
REQ-006 SHALL have port port_req  in  N_PORTS x t_mpf_vtp_lookup_req: pageVA, isSpeculative, port-local tag.
REQ-007 SHALL have port port_req_ready  out  N_PORTS: grant; a request transfers when valid and ready are both high.
REQ-008 SHALL have port port_rsp_valid  out  N_PORTS: per-port response valid, one-hot or zero.
REQ-009 SHALL have port port_rsp  out  t_mpf_vtp_lookup_rsp: response broadcast to all ports, tag restored to the port-local value.
REQ-010 SHALL have port svc_req_valid  out  1, svc_req  out  t_mpf_vtp_lookup_req, svc_req_ready  in  1: service-side request handshake; svc_req.tag carries the service tag.
REQ-011 SHALL have port svc_rsp_valid  in  1, svc_rsp  in  t_mpf_vtp_lookup_rsp: service response; no backpressure.
REQ-012 SHALL have port tag_exhausted_cycles  out  32: statistics counter (see Configuration).

Function
REQ-013 SHALL keep a free-tag bitmap of N_TAGS bits; the allocator SHALL pick the lowest-numbered free tag.
REQ-014 SHALL keep a tag table indexed by service tag holding {port id, port-local tag}, written on allocation.
REQ-015 SHALL arbitrate round-robin; the pointer SHALL advance to the port after the granted port, and only on a transfer.
REQ-016 SHALL grant at most one port per cycle, and only when a free tag exists and the output register is empty or is being drained this cycle (svc_req_valid and svc_req_ready).
REQ-017 On a transfer, SHALL load svc_req with pageVA/isSpeculative unchanged and the allocated tag, and assert svc_req_valid on the next cycle (1-cycle latency).
REQ-018 SHALL hold svc_req_valid and svc_req stable until svc_req_ready is sampled high.
REQ-019 On svc_rsp_valid, SHALL look up the tag table and, one cycle later, assert exactly one port_rsp_valid bit with pagePA/error/isBigPage/mayCache copied and tag replaced by the stored port-local tag.
REQ-020 SHALL free the response's tag at the same edge the response is registered; a freed tag SHALL NOT be allocated in that same cycle.
REQ-021 All tags in use: port_req_ready SHALL be all zero until a response frees a tag.
REQ-022 A response arriving for a tag that is already free SHALL be dropped (no port_rsp_valid); simulation SHALL flag an assertion error.
REQ-023 Simultaneous allocation and response for different tags SHALL both complete in the same cycle.

Reset
REQ-024 While reset is high: all tags free, round-robin pointer = 0, svc_req_valid = 0, port_rsp_valid = 0, tag_exhausted_cycles = 0; port_req_ready SHALL be 0.
REQ-025 Reset mid-operation SHALL discard in-flight requests and tags; responses received after reset deassertion for discarded tags SHALL follow REQ-022.

Configuration
REQ-026 Macro MPF_VTP_SVC_ARB_STATS_EN defined: tag_exhausted_cycles SHALL increment (saturating at 2^32-1) each cycle in which any port_req_valid is high and no free tag exists.
REQ-027 Macro undefined: tag_exhausted_cycles SHALL be tied to 0 and no counter logic SHALL be synthesized.

Verification
REQ-028 Single request, port 0, pageVA=0x123, local tag 7 -> svc_req_valid next cycle with tag 0; response with tag 0 and pagePA=0x456 -> port_rsp_valid=01, tag 7, pagePA 0x456 one cycle later.
REQ-029 Ports 0 and 1 both valid continuously, svc_req_ready=1 -> grants alternate 0,1,0,1; service tags 0,1,2,3.
REQ-030 Issue 32 requests with no responses -> 33rd request stalls with port_req_ready=0; respond with tag 5 -> next grant uses tag 5 two cycles after the response.
REQ-031 svc_req_ready held low 4 cycles -> svc_req stable, no further grants; ready high -> drain and new grant in the same cycle.
REQ-032 Responses returned out of order (tags 2,0,1) -> each is routed to its originating port with the correct local tag.
REQ-033 With MPF_VTP_SVC_ARB_STATS_EN, 10 stalled cycles at full occupancy -> tag_exhausted_cycles=10; assert reset mid-traffic -> all outputs return to REQ-024 values.
